// File: rtl/line_reader_pkg.sv
// Shared constants and FSM encoding for the ping-pong line buffer read side.
package line_reader_pkg;

  localparam int unsigned ADC_WIDTH  = 14;
  localparam int unsigned PIX_IN_ROW = 384;
  localparam int unsigned FRAME_ROWS = 288;
  localparam int unsigned BUF_ADDR_W = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } rd_state_e;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/line_reader_skid.sv
// Two-entry skid FIFO; the head register drives the stream directly so outputs stay registered.
module line_reader_skid #(
  parameter int unsigned W = 16
) (
  input  logic         CLK,
  input  logic         RESET_N,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] dout,
  output logic [1:0]   count_c
);

  logic [W-1:0] head_q, head_d, tail_q, tail_d;
  logic         hv_q, hv_d, tv_q, tv_d;
  logic         pop_c;

  assign pop_c = hv_q && ready;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    hv_d   = hv_q;
    tv_d   = tv_q;
    if (pop_c) begin
      if (tv_q) begin
        head_d = tail_q;
        tv_d   = push;
        if (push) tail_d = din;
      end else begin
        hv_d = push;
        if (push) head_d = din;
      end
    end else if (push) begin
      if (!hv_q) begin
        hv_d   = 1'b1;
        head_d = din;
      end else begin
        tv_d   = 1'b1;
        tail_d = din;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      head_q <= '0;
      tail_q <= '0;
      hv_q   <= 1'b0;
      tv_q   <= 1'b0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      hv_q   <= hv_d;
      tv_q   <= tv_d;
    end
  end

  assign valid   = hv_q;
  assign dout    = head_q;
  assign count_c = {1'b0, hv_q} + {1'b0, tv_q};

endmodule

// File: rtl/line_reader.sv
// Read-side sequencer for the ping-pong ADC line buffer: bank swap, line read, SOF/EOL stream.
// Optional READER_TEST_PATTERN_EN adds TEST_MODE, replacing pixel data with {row, index}.
module line_reader
  import line_reader_pkg::*;
#(
  parameter int unsigned DATA_W       = ADC_WIDTH,
  parameter int unsigned PIX_PER_LINE = PIX_IN_ROW,
  parameter int unsigned ROWS         = FRAME_ROWS,
  parameter int unsigned ADDR_W       = BUF_ADDR_W
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              FRAME_START,
  input  logic              LINE_READY,
  output logic              BUF_BANK,
  output logic              BUF_RD_EN,
  output logic [ADDR_W-1:0] BUF_RD_ADDR,
  input  logic [DATA_W-1:0] BUF_DATA,
  output logic [DATA_W-1:0] PIX_DATA,
  output logic              PIX_VALID,
  input  logic              PIX_READY,
  output logic              PIX_SOF,
  output logic              PIX_EOL,
  output logic              OVERRUN
`ifdef READER_TEST_PATTERN_EN
  ,
  input  logic              TEST_MODE
`endif
);

  localparam int unsigned ROW_W  = cnt_w(ROWS);
  localparam int unsigned IDX_W  = cnt_w(PIX_PER_LINE);
  localparam int unsigned SKID_W = DATA_W + 2;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIX_PER_LINE - 1);
  localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(ROWS - 1);

  rd_state_e         state_q, state_d;
  logic              bank_q, bank_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic              pend_q, pend_d;
  logic              overrun_q, overrun_d;

  // Tags travelling alongside the read that is one cycle in flight.
  logic              dv_q, sof_q, eol_q;
`ifdef READER_TEST_PATTERN_EN
  logic [IDX_W-1:0]  idx_q;
`endif

  logic              rd_en_c, pop_c, eol_xfer_c;
  logic [2:0]        occ_c;
  logic [1:0]        skid_count_c;
  logic [DATA_W-1:0] pix_in_c;
  logic [SKID_W-1:0] skid_out;

  assign pop_c      = PIX_VALID && PIX_READY;
  assign eol_xfer_c = pop_c && PIX_EOL;

  // Occupancy once this cycle's pop leaves; a new read is allowed only if it can never overflow.
  assign occ_c   = 3'(skid_count_c) + 3'(dv_q) - 3'(pop_c);
  assign rd_en_c = (state_q == READ) && (occ_c < 3'd2);

  always_comb begin
    state_d   = state_q;
    bank_d    = bank_q;
    addr_d    = addr_q;
    row_d     = row_q;
    pend_d    = pend_q;
    overrun_d = overrun_q;

    if (FRAME_START) overrun_d = 1'b0;
    if (LINE_READY && (state_q != IDLE)) overrun_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (FRAME_START) begin
          row_d  = '0;
          pend_d = 1'b0;
        end
        if (LINE_READY) begin
          bank_d  = !bank_q;
          addr_d  = '0;
          state_d = READ;
        end
      end
      READ: begin
        if (rd_en_c) begin
          if (addr_q == LAST_ADDR) state_d = DRAIN;
          else                     addr_d  = addr_q + ADDR_W'(1);
        end
      end
      DRAIN: begin
        if (eol_xfer_c) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A mid-line frame start is deferred so the running line keeps its row tag.
    if ((state_q != IDLE) && FRAME_START) pend_d = 1'b1;
    if (eol_xfer_c) begin
      pend_d = 1'b0;
      if (FRAME_START || pend_q || (row_q == LAST_ROW)) row_d = '0;
      else                                              row_d = row_q + ROW_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= IDLE;
      bank_q    <= 1'b0;
      addr_q    <= '0;
      row_q     <= '0;
      pend_q    <= 1'b0;
      overrun_q <= 1'b0;
      dv_q      <= 1'b0;
      sof_q     <= 1'b0;
      eol_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bank_q    <= bank_d;
      addr_q    <= addr_d;
      row_q     <= row_d;
      pend_q    <= pend_d;
      overrun_q <= overrun_d;
      dv_q      <= rd_en_c;
      if (rd_en_c) begin
        sof_q <= (addr_q == '0) && (row_q == '0);
        eol_q <= (addr_q == LAST_ADDR);
      end
    end
  end

`ifdef READER_TEST_PATTERN_EN
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)     idx_q <= '0;
    else if (rd_en_c) idx_q <= IDX_W'(addr_q);
  end

  assign pix_in_c = TEST_MODE ? DATA_W'({row_q, idx_q}) : BUF_DATA;
`else
  assign pix_in_c = BUF_DATA;
`endif

  line_reader_skid #(
    .W(SKID_W)
  ) u_skid (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .push    (dv_q),
    .din     ({sof_q, eol_q, pix_in_c}),
    .ready   (PIX_READY),
    .valid   (PIX_VALID),
    .dout    (skid_out),
    .count_c (skid_count_c)
  );

  assign {PIX_SOF, PIX_EOL, PIX_DATA} = skid_out;

  assign BUF_BANK    = bank_q;
  assign BUF_RD_EN   = rd_en_c;
  assign BUF_RD_ADDR = addr_q;
  assign OVERRUN     = overrun_q;

endmodule

// File: tb/tb_line_reader.sv
// Directed bench for line_reader with a pixel scoreboard fed at line start and drained at the stream.
module tb_line_reader;
  import line_reader_pkg::*;

  localparam int unsigned DW      = 14;
  localparam int unsigned AW      = 10;
  localparam int unsigned PPL     = 384;
  // Short frame keeps the row-wrap check within a small cycle budget.
  localparam int unsigned TB_ROWS = 5;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sof;
    logic          eol;
  } exp_t;

  logic          CLK, RESET_N, FRAME_START, LINE_READY, PIX_READY, TEST_MODE;
  logic          BUF_BANK, BUF_RD_EN, PIX_VALID, PIX_SOF, PIX_EOL, OVERRUN;
  logic [AW-1:0] BUF_RD_ADDR;
  logic [DW-1:0] buf_data, PIX_DATA;

  exp_t          sb[$];
  int            checks = 0;
  int            failures = 0;
  int            model_row = 0;
  bit            model_pend = 0;
  bit            exp_bank = 0;
  bit            tm = 0;
  bit            held_v = 0;
  logic [16:0]   held = '0;

  line_reader #(.ROWS(TB_ROWS)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .FRAME_START(FRAME_START), .LINE_READY(LINE_READY),
    .BUF_BANK(BUF_BANK), .BUF_RD_EN(BUF_RD_EN), .BUF_RD_ADDR(BUF_RD_ADDR), .BUF_DATA(buf_data),
    .PIX_DATA(PIX_DATA), .PIX_VALID(PIX_VALID), .PIX_READY(PIX_READY), .PIX_SOF(PIX_SOF),
    .PIX_EOL(PIX_EOL), .OVERRUN(OVERRUN)
`ifdef READER_TEST_PATTERN_EN
    , .TEST_MODE(TEST_MODE)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Synchronous buffer model: data one cycle after the read strobe.
  always @(posedge CLK) if (BUF_RD_EN) buf_data <= DW'(BUF_RD_ADDR) + DW'(1000);

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push_line(input int row);
    exp_t e;
    for (int i = 0; i < PPL; i++) begin
      e.data = tm ? DW'((row << 9) | i) : DW'(i + 1000);
      e.sof  = (row == 0) && (i == 0);
      e.eol  = (i == PPL - 1);
      sb.push_back(e);
    end
  endtask

  // One clock: stream checks at the falling edge, then step past the rising edge.
  task automatic cycle();
    exp_t e;
    @(negedge CLK);
    if (held_v) check("stall_stable", {15'd0, PIX_VALID, PIX_SOF, PIX_EOL, PIX_DATA}, {15'd0, held});
    if (PIX_VALID && PIX_READY) begin
      check("pixel_expected", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("pix_data", 32'(PIX_DATA), 32'(e.data));
        check("pix_sof_eol", {30'd0, PIX_SOF, PIX_EOL}, {30'd0, e.sof, e.eol});
      end
    end
    held_v = PIX_VALID && !PIX_READY;
    held   = {PIX_VALID, PIX_SOF, PIX_EOL, PIX_DATA};
    @(posedge CLK);
    #1;
  endtask

  task automatic line_ready(input bit accept);
    LINE_READY = 1'b1;
    if (accept) begin
      push_line(model_row);
      exp_bank = !exp_bank;
    end
    cycle();
    LINE_READY = 1'b0;
  endtask

  task automatic finish_line(input bit rnd);
    int n = 0;
    while (!((dut.state_q == IDLE) && (sb.size() == 0)) && (n < 3000)) begin
      PIX_READY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      cycle();
      n++;
    end
    PIX_READY = 1'b1;
    check("line_done_in_budget", 32'(n < 3000), 1);
    model_row  = (model_pend || (model_row == TB_ROWS - 1)) ? 0 : model_row + 1;
    model_pend = 0;
    tm = 0;
    TEST_MODE = 1'b0;
  endtask

  initial begin
    int n;
    RESET_N = 1'b0; FRAME_START = 1'b0; LINE_READY = 1'b0; PIX_READY = 1'b1; TEST_MODE = 1'b0;
    repeat (3) cycle();
    check("reset_outputs", {2'd0, BUF_BANK, BUF_RD_EN, BUF_RD_ADDR, PIX_DATA, PIX_VALID, PIX_SOF,
                            PIX_EOL, OVERRUN}, 32'd0);
    RESET_N = 1'b1;
    cycle();

    // Full-rate line: first valid two edges after LINE_READY, idle after PPL+2.
    FRAME_START = 1'b1; cycle(); FRAME_START = 1'b0;
    model_row = 0;
    line_ready(1);
    check("bank_first_line", 32'(BUF_BANK), 1);
    cycle();
    check("valid_not_yet", 32'(PIX_VALID), 0);
    cycle();
    check("first_valid_latency", 32'(PIX_VALID), 1);
    n = 2;
    while ((dut.state_q != IDLE) && (n < 1000)) begin
      cycle();
      n++;
    end
    check("line_cycles", 32'(n), 32'(PPL + 2));
    check("line_fully_sent", 32'(sb.size()), 0);
    model_row = 1;

    // Random backpressure.
    line_ready(1);
    finish_line(1);

    // LINE_READY while busy.
    line_ready(1);
    repeat (100) cycle();
    line_ready(0);
    check("overrun_set", 32'(OVERRUN), 1);
    check("bank_unchanged", 32'(BUF_BANK), 32'(exp_bank));
    finish_line(0);
    check("overrun_sticky", 32'(OVERRUN), 1);

    // FRAME_START with LINE_READY: cleared first, line accepted as row 0.
    FRAME_START = 1'b1;
    model_row = 0;
    model_pend = 0;
    line_ready(1);
    FRAME_START = 1'b0;
    check("overrun_cleared", 32'(OVERRUN), 0);
    finish_line(0);

    // Row wrap and bank alternation across a frame.
    FRAME_START = 1'b1; cycle(); FRAME_START = 1'b0;
    model_row = 0;
    for (int l = 0; l <= TB_ROWS; l++) begin
`ifdef READER_TEST_PATTERN_EN
      if (model_row == 3) begin
        tm = 1;
        TEST_MODE = 1'b1;
      end
`endif
      line_ready(1);
      check("bank_alternate", 32'(BUF_BANK), 32'(exp_bank));
      finish_line(0);
    end

    // FRAME_START mid-line: current line keeps its row, next line is row 0.
    line_ready(1);
    repeat (50) cycle();
    FRAME_START = 1'b1; model_pend = 1; cycle(); FRAME_START = 1'b0;
    finish_line(0);
    line_ready(1);
    finish_line(0);

    // FRAME_START on the EOL transfer cycle.
    line_ready(1);
    n = 0;
    while (!(PIX_VALID && PIX_EOL) && (n < 1000)) begin
      cycle();
      n++;
    end
    check("eol_seen", 32'(n < 1000), 1);
    FRAME_START = 1'b1; model_pend = 1; cycle(); FRAME_START = 1'b0;
    finish_line(0);
    line_ready(1);
    finish_line(0);

    // Reset mid-line drops the partial line.
    line_ready(1);
    repeat (200) cycle();
    check("valid_before_reset", 32'(PIX_VALID), 1);
    RESET_N = 1'b0;
    #1;
    check("async_reset_outputs", {2'd0, BUF_BANK, BUF_RD_EN, BUF_RD_ADDR, PIX_DATA, PIX_VALID,
                                  PIX_SOF, PIX_EOL, OVERRUN}, 32'd0);
    sb.delete();
    held_v = 0;
    exp_bank = 0;
    model_row = 0;
    model_pend = 0;
    repeat (2) cycle();
    RESET_N = 1'b1;
    cycle();
    line_ready(1);
    check("restart_bank", 32'(BUF_BANK), 1);
    check("restart_read", {21'd0, BUF_RD_EN, BUF_RD_ADDR}, {21'd0, 1'b1, 10'd0});
    finish_line(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
